// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data memory controller.
package dmem_pkg;

    localparam int unsigned ADDR_BITS_DEF = 8;
    localparam int unsigned DATA_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RELAY
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i wins, wrapping.
module rr_arbiter #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              any_req_o
);

    int unsigned j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_req_o = 1'b0;
        j         = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            j = (32'(ptr_i) + k) % NumReq;
            if (!any_req_o && req_i[j]) begin
                any_req_o = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/data_mem_controller.sv
// Round-robin arbiter of per-LSU load/store requests onto one data memory port.
// Optional macro DMEM_CTRL_STATS_EN adds saturating read/write completion counters.
module data_mem_controller
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = ADDR_BITS_DEF,
    parameter int unsigned DATA_BITS     = DATA_BITS_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef DMEM_CTRL_STATS_EN
    output logic [15:0]                       stat_reads,
    output logic [15:0]                       stat_writes,
`endif
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_addr,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_addr,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                              mem_read_valid,
    output logic [ADDR_BITS-1:0]              mem_read_addr,
    input  logic                              mem_read_ready,
    input  logic [DATA_BITS-1:0]              mem_read_data,
    output logic                              mem_write_valid,
    output logic [ADDR_BITS-1:0]              mem_write_addr,
    output logic [DATA_BITS-1:0]              mem_write_data,
    input  logic                              mem_write_ready
);

    localparam int unsigned IdxW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    ctrl_state_t                              state_q, state_d;
    logic [IdxW-1:0]                          grant_q, grant_d;
    logic [IdxW-1:0]                          rr_ptr_q, rr_ptr_d;
    logic                                     mrv_q, mrv_d;
    logic [ADDR_BITS-1:0]                     mra_q, mra_d;
    logic                                     mwv_q, mwv_d;
    logic [ADDR_BITS-1:0]                     mwa_q, mwa_d;
    logic [DATA_BITS-1:0]                     mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]                 rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]                 wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  rd_data_q, rd_data_d;

    logic [NUM_CONSUMERS-1:0] gnt_oh;
    logic [IdxW-1:0]          gnt_idx;
    logic                     any_req;

    rr_arbiter #(
        .NumReq (NUM_CONSUMERS),
        .IdxW   (IdxW)
    ) u_arb (
        .req_i     (consumer_read_valid | consumer_write_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        mrv_d      = mrv_q;
        mra_d      = mra_q;
        mwv_d      = mwv_q;
        mwa_d      = mwa_q;
        mwd_d      = mwd_q;
        rd_ready_d = rd_ready_q;
        wr_ready_d = wr_ready_q;
        rd_data_d  = rd_data_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = gnt_idx;
                    // Read wins over write within the granted consumer.
                    if (|(gnt_oh & consumer_read_valid)) begin
                        mrv_d   = 1'b1;
                        mra_d   = consumer_read_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
                        state_d = READ_WAIT;
                    end else begin
                        mwv_d   = 1'b1;
                        mwa_d   = consumer_write_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
                        mwd_d   = consumer_write_data[gnt_idx*DATA_BITS +: DATA_BITS];
                        state_d = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    rd_data_d[grant_q]  = mem_read_data;
                    rd_ready_d[grant_q] = 1'b1;
                    mrv_d               = 1'b0;
                    state_d             = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    wr_ready_d[grant_q] = 1'b1;
                    mwv_d               = 1'b0;
                    state_d             = RELAY;
                end
            end
            RELAY: begin
                if ((rd_ready_q[grant_q] && !consumer_read_valid[grant_q]) ||
                    (wr_ready_q[grant_q] && !consumer_write_valid[grant_q])) begin
                    rd_ready_d = '0;
                    wr_ready_d = '0;
                    rr_ptr_d   = (grant_q == IdxW'(NUM_CONSUMERS - 1)) ? '0 : grant_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            mrv_q      <= 1'b0;
            mra_q      <= '0;
            mwv_q      <= 1'b0;
            mwa_q      <= '0;
            mwd_q      <= '0;
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            mrv_q      <= mrv_d;
            mra_q      <= mra_d;
            mwv_q      <= mwv_d;
            mwa_q      <= mwa_d;
            mwd_q      <= mwd_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_read_addr        = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_addr       = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_read_ready  = rd_ready_q;
    assign consumer_write_ready = wr_ready_q;
    assign consumer_read_data   = rd_data_q;

`ifdef DMEM_CTRL_STATS_EN
    logic [15:0] stat_reads_q, stat_reads_d;
    logic [15:0] stat_writes_q, stat_writes_d;

    // Counted on entry to RELAY, i.e. when the memory handshake completes.
    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        if (state_q == READ_WAIT && mem_read_ready && stat_reads_q != 16'hFFFF) begin
            stat_reads_d = stat_reads_q + 16'd1;
        end
        if (state_q == WRITE_WAIT && mem_write_ready && stat_writes_q != 16'hFFFF) begin
            stat_writes_d = stat_writes_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: vector table plus arbitration, stall and reset sequences.
module tb_data_mem_controller;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      rd_valid, rd_ready, wr_valid, wr_ready;
    logic [N*AW-1:0]   rd_addr, wr_addr;
    logic [N*DW-1:0]   rd_data, wr_data;
    logic              mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
    logic [AW-1:0]     mem_read_addr, mem_write_addr;
    logic [DW-1:0]     mem_read_data, mem_write_data;
`ifdef DMEM_CTRL_STATS_EN
    logic [15:0]       stat_reads, stat_writes;
`endif

    int total = 0;
    int bad   = 0;
    int n_rd  = 0;
    int n_wr  = 0;
    logic [DW-1:0] last_rd [N];

    always #5 clk = ~clk;

    data_mem_controller #(
        .NUM_CONSUMERS (N),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
`ifdef DMEM_CTRL_STATS_EN
        .stat_reads           (stat_reads),
        .stat_writes          (stat_writes),
`endif
        .consumer_read_valid  (rd_valid),
        .consumer_read_addr   (rd_addr),
        .consumer_read_ready  (rd_ready),
        .consumer_read_data   (rd_data),
        .consumer_write_valid (wr_valid),
        .consumer_write_addr  (wr_addr),
        .consumer_write_data  (wr_data),
        .consumer_write_ready (wr_ready),
        .mem_read_valid       (mem_read_valid),
        .mem_read_addr        (mem_read_addr),
        .mem_read_ready       (mem_read_ready),
        .mem_read_data        (mem_read_data),
        .mem_write_valid      (mem_write_valid),
        .mem_write_addr       (mem_write_addr),
        .mem_write_data       (mem_write_data),
        .mem_write_ready      (mem_write_ready)
    );

    typedef struct {
        bit            wr;
        int            c;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;     // write data, or data memory returns for a read
        int            delay;    // cycles memory stalls before ready
        logic [N-1:0]  exp_mask; // expected consumer ready vector
        logic [DW-1:0] exp_data; // expected mem_write_data / consumer_read_data
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            total++;
            if (mem_read_valid && mem_write_valid) begin
                bad++;
                $display("FAIL both_mem_valid: got 1 expected 0");
            end
        end
    end

    task automatic wait_mem(input bit is_wr);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (is_wr ? mem_write_valid : mem_read_valid) ok = 1'b1;
            else tick();
        end
        chk(is_wr ? "wait_mem_write_valid" : "wait_mem_read_valid", 32'(ok), 32'd1);
    endtask

    task automatic serve_read(input int c, input logic [AW-1:0] addr, input logic [DW-1:0] md,
                              input int delay, input logic [N-1:0] mask,
                              input logic [DW-1:0] exp);
        wait_mem(1'b0);
        chk("mem_read_addr", 32'(mem_read_addr), 32'(addr));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("mem_read_valid_hold", 32'(mem_read_valid), 32'd1);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = md;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        chk("rd_ready", 32'(rd_ready), 32'(mask));
        chk("rd_data", 32'(rd_data[c*DW +: DW]), 32'(exp));
        chk("mem_read_valid_drop", 32'(mem_read_valid), 32'd0);
        tick();
        chk("rd_ready_held", 32'(rd_ready), 32'(mask));
        rd_valid[c] = 1'b0;
        tick();
        chk("rd_ready_clear", 32'(rd_ready), 32'd0);
        last_rd[c] = exp;
        n_rd++;
    endtask

    task automatic serve_write(input int c, input logic [AW-1:0] addr, input int delay,
                               input logic [N-1:0] mask, input logic [DW-1:0] exp);
        wait_mem(1'b1);
        chk("mem_write_addr", 32'(mem_write_addr), 32'(addr));
        chk("mem_write_data", 32'(mem_write_data), 32'(exp));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("mem_write_valid_hold", 32'(mem_write_valid), 32'd1);
        end
        mem_write_ready = 1'b1;
        tick();
        mem_write_ready = 1'b0;
        chk("wr_ready", 32'(wr_ready), 32'(mask));
        chk("mem_write_valid_drop", 32'(mem_write_valid), 32'd0);
        tick();
        chk("wr_ready_held", 32'(wr_ready), 32'(mask));
        wr_valid[c] = 1'b0;
        tick();
        chk("wr_ready_clear", 32'(wr_ready), 32'd0);
        n_wr++;
    endtask

    task automatic req_read(input int c, input logic [AW-1:0] addr);
        rd_valid[c]          = 1'b1;
        rd_addr[c*AW +: AW]  = addr;
    endtask

    task automatic req_write(input int c, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        wr_valid[c]          = 1'b1;
        wr_addr[c*AW +: AW]  = addr;
        wr_data[c*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rd_valid = '0;
        wr_valid = '0;
        tick();
        reset = 1'b0;
        n_rd = 0;
        n_wr = 0;
        for (int i = 0; i < N; i++) last_rd[i] = '0;
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{0, 0, 8'd42,  8'd50,  0, 4'b0001, 8'd50};
        vecs[1] = '{1, 2, 8'd32,  8'd63,  0, 4'b0100, 8'd63};
        vecs[2] = '{0, 3, 8'd255, 8'hA5,  2, 4'b1000, 8'hA5};
        vecs[3] = '{1, 1, 8'd0,   8'hFF,  1, 4'b0010, 8'hFF};
        vecs[4] = '{0, 1, 8'd7,   8'h3C,  0, 4'b0010, 8'h3C};
        vecs[5] = '{1, 0, 8'd200, 8'h01,  3, 4'b0001, 8'h01};
        vecs[6] = '{0, 2, 8'd128, 8'h00,  1, 4'b0100, 8'h00};
        vecs[7] = '{0, 0, 8'd1,   8'h77,  0, 4'b0001, 8'h77};

        reset = 1'b1;
        rd_valid = '0; wr_valid = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_rd = 0; n_wr = 0;
        for (int i = 0; i < N; i++) last_rd[i] = '0;

        chk("reset_mem_read_valid", 32'(mem_read_valid), 32'd0);
        chk("reset_mem_write_valid", 32'(mem_write_valid), 32'd0);
        chk("reset_readies", 32'({rd_ready, wr_ready}), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].wr) begin
                req_write(vecs[v].c, vecs[v].addr, vecs[v].data);
                serve_write(vecs[v].c, vecs[v].addr, vecs[v].delay, vecs[v].exp_mask,
                            vecs[v].exp_data);
            end else begin
                req_read(vecs[v].c, vecs[v].addr);
                serve_read(vecs[v].c, vecs[v].addr, vecs[v].data, vecs[v].delay,
                           vecs[v].exp_mask, vecs[v].exp_data);
            end
            tick();
        end
        for (int i = 0; i < N; i++) chk("rd_data_kept", 32'(rd_data[i*DW +: DW]), 32'(last_rd[i]));

        // Early valid drop during READ_WAIT: ready lasts one cycle.
        req_read(3, 8'd9);
        wait_mem(1'b0);
        rd_valid[3] = 1'b0;
        mem_read_ready = 1'b1; mem_read_data = 8'h5A;
        tick();
        mem_read_ready = 1'b0;
        chk("early_drop_ready", 32'(rd_ready), 32'b1000);
        chk("early_drop_data", 32'(rd_data[3*DW +: DW]), 32'h5A);
        tick();
        chk("early_drop_pulse", 32'(rd_ready), 32'd0);
        tick();

        // Stall then reset mid-transaction.
        req_read(2, 8'd77);
        wait_mem(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", 32'(mem_read_valid), 32'd1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_valid = '0;
        n_rd = 0; n_wr = 0;
        for (int i = 0; i < N; i++) last_rd[i] = '0;
        chk("rst_mid_mem_read_valid", 32'(mem_read_valid), 32'd0);
        chk("rst_mid_readies", 32'({rd_ready, wr_ready}), 32'd0);
        chk("rst_mid_rd_data", rd_data, 32'd0);
        tick();
        req_read(2, 8'd78);
        serve_read(2, 8'd78, 8'h9E, 0, 4'b0100, 8'h9E);
        do_reset();

        // Round-robin: all four read together, then 0 and 1 again.
        for (int c = 0; c < N; c++) req_read(c, 8'(10 + c));
        for (int c = 0; c < N; c++) serve_read(c, 8'(10 + c), 8'(8'h20 + c), 0, 4'(1 << c),
                                               8'(8'h20 + c));
        req_read(0, 8'd10);
        req_read(1, 8'd11);
        serve_read(0, 8'd10, 8'h30, 0, 4'b0001, 8'h30);
        serve_read(1, 8'd11, 8'h31, 0, 4'b0010, 8'h31);

        // Same consumer read and write: read first, write on a later grant.
        req_read(1, 8'd5);
        req_write(1, 8'd6, 8'hC3);
        serve_read(1, 8'd5, 8'h44, 0, 4'b0010, 8'h44);
        serve_write(1, 8'd6, 0, 4'b0010, 8'hC3);
        req_write(3, 8'd99, 8'h12);
        serve_write(3, 8'd99, 0, 4'b1000, 8'h12);

`ifdef DMEM_CTRL_STATS_EN
        chk("stat_reads", 32'(stat_reads), 32'(n_rd));
        chk("stat_writes", 32'(stat_writes), 32'(n_wr));
        do_reset();
        chk("stat_reads_reset", 32'(stat_reads), 32'd0);
        chk("stat_writes_reset", 32'(stat_writes), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
